// File: rtl/frame_sync_pkg.sv
// Shared types and default constants for the SNES/HDMI frame-sync controller.
package frame_sync_pkg;

    localparam int         FS_CNT_W              = 20;
    localparam logic [7:0] FS_DEF_SYNC_LINE      = 8'd2;
    localparam logic [7:0] FS_DEF_REARM_LINE     = 8'd200;
    localparam int         FS_DEF_SYNC_STAGES    = 2;
    localparam int         FS_DEF_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_PAUSED = 3'd2,
        ST_DONE   = 3'd3
    } fs_state_t;

endpackage

// File: rtl/frame_sync_ctrl_sync_edge_detect.sv
// Multi-flop synchronizer for an async level, followed by a rising-edge pulse.
// Pulse is seen by downstream logic STAGES+1 edges after the input is first sampled.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg[0] <= 1'b0;
            prev_reg    <= 1'b0;
        end else begin
            sync_reg[0] <= din;
            prev_reg    <= sync_reg[STAGES-1];
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!resetn) sync_reg[gi] <= 1'b0;
                else         sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign pulse = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Pauses the SNES core once per frame until the HDMI side starts its first line,
// releasing only on an even paused-cycle count. Optional FRAME_SYNC_STATS_EN adds counters.
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter logic [7:0] SYNC_LINE      = FS_DEF_SYNC_LINE,
    parameter logic [7:0] REARM_LINE     = FS_DEF_REARM_LINE,
    parameter int         SYNC_STAGES    = FS_DEF_SYNC_STAGES,
    parameter int         TIMEOUT_CYCLES = FS_DEF_TIMEOUT_CYCLES,
    parameter int         CNT_W          = FS_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [7:0]       snes_y,
    input  logic             snes_refresh,
    input  logic             hdmi_frame_start,
    output logic             pause,
    output logic [2:0]       state,
    output logic             locked,
    output logic             lost_sync,
    output logic [CNT_W-1:0] last_pause_len,
    output logic [15:0]      frame_cnt,
    output logic [CNT_W-1:0] max_pause_len
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    fs_state_t        state_reg, state_next;
    logic             pause_reg, pause_next;
    logic             locked_reg, locked_next;
    logic             lost_sync_reg, lost_sync_next;
    logic             start_seen_reg, start_seen_next;
    logic [CNT_W-1:0] pause_cnt_reg, pause_cnt_next;
    logic [CNT_W-1:0] last_len_reg, last_len_next;
    logic             hs_pulse;
    logic             cnt_even;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_hs_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    (hdmi_frame_start),
        .pulse  (hs_pulse)
    );

    assign cnt_even = ~pause_cnt_reg[0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            pause_reg      <= 1'b0;
            locked_reg     <= 1'b0;
            lost_sync_reg  <= 1'b0;
            start_seen_reg <= 1'b0;
            pause_cnt_reg  <= '0;
            last_len_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            pause_reg      <= pause_next;
            locked_reg     <= locked_next;
            lost_sync_reg  <= lost_sync_next;
            start_seen_reg <= start_seen_next;
            pause_cnt_reg  <= pause_cnt_next;
            last_len_reg   <= last_len_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pause_next      = pause_reg;
        locked_next     = locked_reg;
        lost_sync_next  = 1'b0;
        start_seen_next = start_seen_reg;
        pause_cnt_next  = pause_cnt_reg;
        last_len_next   = last_len_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (snes_y == SYNC_LINE && snes_refresh) begin
                    state_next      = ST_PAUSED;
                    pause_next      = 1'b1;
                    pause_cnt_next  = CNT_W'(1);
                    start_seen_next = 1'b0;
                end
            end
            ST_PAUSED: begin
                pause_cnt_next = (&pause_cnt_reg) ? pause_cnt_reg : pause_cnt_reg + 1'b1;
                if (hs_pulse) start_seen_next = 1'b1;
                // Normal release outranks timeout and enable-drop; all require an even count.
                if (start_seen_reg && cnt_even) begin
                    state_next    = ST_DONE;
                    pause_next    = 1'b0;
                    locked_next   = 1'b1;
                    last_len_next = pause_cnt_reg;
                end else if (pause_cnt_reg == TMO) begin
                    state_next     = ST_DONE;
                    pause_next     = 1'b0;
                    locked_next    = 1'b0;
                    lost_sync_next = 1'b1;
                    last_len_next  = pause_cnt_reg;
                end else if (!enable && cnt_even) begin
                    state_next    = ST_IDLE;
                    pause_next    = 1'b0;
                    locked_next   = 1'b0;
                    last_len_next = pause_cnt_reg;
                end
            end
            ST_DONE: begin
                if (!enable)                  state_next = ST_IDLE;
                else if (snes_y == REARM_LINE) state_next = ST_ARMED;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pause          = pause_reg;
    assign state          = state_reg;
    assign locked         = locked_reg;
    assign lost_sync      = lost_sync_reg;
    assign last_pause_len = last_len_reg;

`ifdef FRAME_SYNC_STATS_EN
    logic [15:0]      frame_cnt_reg;
    logic [CNT_W-1:0] max_len_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_cnt_reg <= '0;
            max_len_reg   <= '0;
        end else begin
            if (state_reg == ST_PAUSED && state_next == ST_DONE && locked_next)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (last_len_reg > max_len_reg)
                max_len_reg <= last_len_reg;
        end
    end

    assign frame_cnt     = frame_cnt_reg;
    assign max_pause_len = max_len_reg;
`else
    assign frame_cnt     = '0;
    assign max_pause_len = '0;
`endif

endmodule

// File: doc/frame_sync_ctrl.md
Name: frame_sync_ctrl

Overview:
Single-clock scheduler that sequences the SNES-side frame-sync pause against the HDMI frame timing. Once per SNES frame it halts the SNES core during a DRAM refresh on a programmed line, and waits for the HDMI pipeline to start its first active line. It then releases the SNES after an even number of paused cycles, which keeps PPU SDRAM slots aligned. It sits between the SNES core (line counter, refresh strobe) and the line-buffer/HDMI converter, and drives the core's pause input.

Parameters:
SYNC_LINE, 8'd2, SNES line on which the pause may begin
REARM_LINE, 8'd200, SNES line at which the next frame's sync is armed
SYNC_STAGES, 2, flops in the hdmi_frame_start synchronizer (minimum 2)
TIMEOUT_CYCLES, 1000000, maximum paused clk cycles before a forced release (even value)
CNT_W, 20, width of pause-length counters

Ports:
clk  in  1  SNES-domain clock
resetn  in  1  synchronous active-low reset
enable  in  1  frame sync enabled; when low, the SNES free-runs
snes_y  in  8  current SNES line number (field bit excluded)
snes_refresh  in  1  SNES DRAM refresh window active
hdmi_frame_start  in  1  async level from the pixel domain; high during the first part of the first active HDMI line, at least 4 clk cycles wide
pause  out  1  pause request to the SNES core (registered)
state  out  3  current FSM state encoding
locked  out  1  last frame completed a normal (non-timeout) sync
lost_sync  out  1  one-cycle pulse on timeout release
last_pause_len  out  CNT_W  paused-cycle count of the most recent completed pause
frame_cnt  out  16  synced frame count (statistics feature only)
max_pause_len  out  CNT_W  largest pause observed (statistics feature only)

Behaviour:
- Reset (resetn low at posedge clk): state=IDLE, pause=0, locked=0, lost_sync=0, last_pause_len=0, synchronizer flops=0, start_seen=0, pause_cnt=0.
- Synchronizer: hdmi_frame_start passes through SYNC_STAGES flops, plus one edge-detect flop. hs_pulse is a one-cycle pulse on each rising edge. Latency from input to hs_pulse is SYNC_STAGES+1 cycles.
- States: IDLE(0), ARMED(1), PAUSED(2), DONE(3).
- IDLE -> ARMED when enable=1. Any state other than PAUSED -> IDLE when enable=0.
- ARMED -> PAUSED on cycle where snes_y==SYNC_LINE && snes_refresh. At that edge: pause<=1, pause_cnt<=1, start_seen<=0.
- PAUSED:
  - pause_cnt increments each cycle and saturates at all-ones.
  - start_seen is set by hs_pulse and is sticky. A pulse that arrived before entry is discarded, so the controller waits for the next HDMI frame.
  - Normal release: start_seen && pause_cnt even. Effects: pause<=0, state<=DONE, locked<=1, last_pause_len<=pause_cnt.
  - Because of this rule, pause is high for exactly pause_cnt cycles, which is always even.
  - The release condition uses registered start_seen. A pulse sets start_seen one cycle before it can release.
- Timeout: pause_cnt==TIMEOUT_CYCLES (even). Effects: same release as normal, except locked<=0 and lost_sync pulses 1 cycle.
- enable=0 while PAUSED: release at the next even pause_cnt. Set locked<=0, then go to IDLE. pause never drops on an odd count.
- DONE -> ARMED when snes_y==REARM_LINE. If snes_y==SYNC_LINE && refresh occurs while in DONE, it is ignored (no second pause per frame).
- If REARM_LINE is reached while in ARMED (no refresh seen on SYNC_LINE), remain ARMED. locked is unchanged.
- Simultaneous events:
  - hs_pulse on the same cycle as the ARMED->PAUSED entry is discarded, because the entry clears start_seen.
  - Timeout and normal release on the same cycle: normal release wins (locked=1, no lost_sync).
- Reset mid-pause drops pause on the next edge. This is the only path that permits an odd pause length.

Optional Feature:
FRAME_SYNC_STATS_EN:
- Defined: frame_cnt increments (wrapping) on every normal release. max_pause_len holds the maximum of last_pause_len since reset. Both reset to 0.
- Undefined: frame_cnt and max_pause_len are tied to 0 and no registers are inferred. All other behaviour is identical.

Decomposition:
- frame_sync_pkg:
  - fs_state_t enum (IDLE/ARMED/PAUSED/DONE, 3-bit)
  - default constants for SYNC_LINE, REARM_LINE, TIMEOUT_CYCLES
  - CNT_W
- Sub-module sync_edge_detect (parameter STAGES): synchronizer chain plus rising-edge pulse. It is reusable for other pixel->SNES crossings.

Test Plan:
- Reset mid-frame with pause high -> next cycle pause=0, state=IDLE, locked=0, last_pause_len=0.
- enable=1, snes_y=2 with refresh pulse; hdmi_frame_start raised 37 cycles later for 8 cycles -> pause stays high until SYNC_STAGES+1 cycles after the rise (plus 1 parity cycle if needed); last_pause_len=40 (even); locked=1; state=DONE.
- hdmi_frame_start pulse 10 cycles before the pause begins, next pulse 5000 cycles after entry -> the first pulse is ignored; release comes from the second pulse; last_pause_len even and ≥5003.
- No hdmi_frame_start with TIMEOUT_CYCLES=1000 -> pause high for exactly 1000 cycles; lost_sync pulses once; locked=0; state=DONE.
- In DONE, snes_y=2 with refresh again -> no pause. snes_y=200 -> ARMED. Next snes_y=2 with refresh -> pause=1.
- enable dropped at pause_cnt=7 -> pause falls after cycle 8; state=IDLE; locked=0. With FRAME_SYNC_STATS_EN, three normal syncs give frame_cnt=3 and max_pause_len equal to the largest of the three pause lengths.
